// File: rtl/pc_gen_if.sv
// Fetch-side bus of the program-counter sequencer: control inputs from the
// pipeline plus the fetch address and the tag/valid of the registered instruction.
interface pc_gen_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic        inst_valid;
  logic        pc_fault;

  // Sequencer side
  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output pc,
    output pc_d,
    output inst_valid,
    output pc_fault
  );

  // Pipeline / fetch side
  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    input  pc,
    input  pc_d,
    input  inst_valid,
    input  pc_fault
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter sequencer in front of an enable-less fetch register.
// Tracks which address the registered instruction belongs to (pc_d) and whether
// it is valid, handles sequential wrap, stall replay and redirect with one bubble.
// Optional macro PC_GEN_BOUND_CHECK_EN: an out-of-range redirect target traps
// into a sticky FAULT state that only rst leaves.
module pc_gen #(
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_WORDS = 8
) (
  input logic        clk,
  input logic        rst,
  pc_gen_if.master   pc_io
);

  typedef enum logic [1:0] {StEmpty, StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  // Tag of the instruction currently held in the fetch register
  logic [31:0] pc_d_q, pc_d_d;
  logic        pc_fault_q, pc_fault_d;
  logic [31:0] fetch_pc_inc;
  logic        target_oob;

  assign fetch_pc_inc = fetch_pc_q + 32'd1;
  assign target_oob   = (pc_io.redirect_target >= 32'(IMEM_WORDS));

  // Next-state decode: redirect beats stall beats advance; FAULT freezes everything
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d_d     = pc_d_q;
    pc_fault_d = pc_fault_q;
    unique case (state_q)
      StEmpty, StRun: begin
        if (pc_io.redirect_valid) begin
`ifdef PC_GEN_BOUND_CHECK_EN
          if (target_oob) begin
            state_d    = StFault;
            pc_fault_d = 1'b1;
          end else begin
            fetch_pc_d = pc_io.redirect_target;
            state_d    = StEmpty;
          end
`else
          // Out-of-range targets are fetched once, then wrap on advance
          fetch_pc_d = pc_io.redirect_target;
          state_d    = StEmpty;
`endif
        end else if (!pc_io.stall) begin
          pc_d_d     = fetch_pc_q;
          fetch_pc_d = (fetch_pc_inc >= 32'(IMEM_WORDS)) ? 32'd0 : fetch_pc_inc;
          state_d    = StRun;
        end
      end
      StFault: begin
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      fetch_pc_q <= 32'(RESET_PC);
      pc_d_q     <= 32'(RESET_PC);
      pc_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_d_q     <= pc_d_d;
      pc_fault_q <= pc_fault_d;
    end
  end

  // Output mux: during a stall of a valid instruction, re-present its address so
  // the enable-less fetch register reloads the same word.
  always_comb begin
    pc_io.pc         = fetch_pc_q;
    pc_io.pc_d       = pc_d_q;
    pc_io.inst_valid = (state_q == StRun);
    if (pc_io.stall && (state_q == StRun) && !pc_io.redirect_valid) begin
      pc_io.pc = pc_d_q;
    end
`ifdef PC_GEN_BOUND_CHECK_EN
    pc_io.pc_fault = pc_fault_q;
`else
    pc_io.pc_fault = 1'b0;
`endif
  end

  // target_oob is only consumed when the bound check is built in
  logic unused_oob;
  assign unused_oob = target_oob;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a behavioural enable-less fetch register.
module tb_pc_gen;
  localparam int unsigned ImemWords = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] mem [16];
  int          n_total = 0;
  int          n_bad   = 0;

  pc_gen_if bus ();

  pc_gen #(
    .RESET_PC   (0),
    .IMEM_WORDS (ImemWords)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_io (bus)
  );

  always #5 clk = ~clk;

  // Fetch stage: registers mem[pc] on every edge, no enable
  always @(posedge clk) instr <= mem[bus.pc[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] exp_pc_d, input logic exp_valid,
                              input logic exp_fault);
    check({tag, ".pc_d"}, bus.pc_d, exp_pc_d);
    check({tag, ".valid"}, 32'(bus.inst_valid), 32'(exp_valid));
    check({tag, ".fault"}, 32'(bus.pc_fault), 32'(exp_fault));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000 + 32'(i);
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'd0;

    // Reset
    tick();
    expect_state("reset", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("reset.pc", bus.pc, 32'd0);

    // First fetches after reset release
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("run", 32'(i), 1'b1, 1'b0);
      check("run.instr", instr, 32'hA000 + 32'(i));
      check("run.pc", bus.pc, 32'(i + 1));
    end

    // Stall three cycles with pc_d = 2
    bus.stall = 1'b1;
    #1;
    check("stall.pc", bus.pc, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("stall", 32'd2, 1'b1, 1'b0);
      check("stall.instr", instr, 32'hA002);
      check("stall.pc_hold", bus.pc, 32'd2);
    end
    bus.stall = 1'b0;
    #1;
    check("unstall.pc", bus.pc, 32'd3);
    tick();
    expect_state("unstall", 32'd3, 1'b1, 1'b0);

    // Free run through the wrap: 4,5,6,7,0,1
    for (int i = 4; i < 10; i++) begin
      tick();
      expect_state("wrap", 32'(i % 8), 1'b1, 1'b0);
      check("wrap.instr", instr, 32'hA000 + 32'(i % 8));
    end

    // Redirect to 5 with pc_d = 1, then again with stall asserted alongside
    for (int rep = 0; rep < 2; rep++) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 32'd5;
      bus.stall = (rep == 1);
      #1;
      check("redir.pc", bus.pc, 32'd2);
      tick();
      expect_state("redir.bubble", 32'd1, 1'b0, 1'b0);
      bus.redirect_valid = 1'b0;
      bus.stall = 1'b0;
      #1;
      check("redir.pc_tgt", bus.pc, 32'd5);
      tick();
      expect_state("redir.tgt", 32'd5, 1'b1, 1'b0);
      check("redir.instr", instr, 32'hA005);
      tick();
      expect_state("redir.next", 32'd6, 1'b1, 1'b0);
      if (rep == 0) begin
        for (int k = 0; k < 3; k++) tick();  // 7, 0, 1
        expect_state("redir.rearm", 32'd1, 1'b1, 1'b0);
      end
    end

    // Out-of-range redirect to 9 from pc_d = 6
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd9;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef PC_GEN_BOUND_CHECK_EN
    expect_state("oob.trap", 32'd6, 1'b0, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd3;
    bus.stall = 1'b1;
    #1;
    check("oob.pc", bus.pc, 32'd7);
    tick();
    expect_state("oob.redir", 32'd6, 1'b0, 1'b1);
    bus.redirect_valid = 1'b0;
    tick();
    expect_state("oob.stall", 32'd6, 1'b0, 1'b1);
    bus.stall = 1'b0;
    tick();
    expect_state("oob.free", 32'd6, 1'b0, 1'b1);
`else
    expect_state("oob.bubble", 32'd6, 1'b0, 1'b0);
    check("oob.pc", bus.pc, 32'd9);
    tick();
    expect_state("oob.tgt", 32'd9, 1'b1, 1'b0);
    check("oob.instr", instr, 32'hA009);
    tick();
    expect_state("oob.wrap", 32'd0, 1'b1, 1'b0);
`endif

    // Reset, run to pc_d = 4, then reset together with a redirect
    rst = 1'b1;
    tick();
    expect_state("rst2", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    expect_state("rst2.run", 32'd4, 1'b1, 1'b0);
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd5;
    tick();
    expect_state("rst3", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    check("rst3.pc", bus.pc, 32'd0);
    tick();
    expect_state("rst3.first", 32'd0, 1'b1, 1'b0);
    check("rst3.instr", instr, 32'hA000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
